seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 71 +++++++
 tb/tb_seq_detect_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with registered flag and match counter
// Optional match counter is built only when SEQ_DETECT_CNT_EN is defined; otherwise match_cnt is tied to 0.
module seq_detect_param #(
    parameter int             PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
    parameter bit             OVERLAP     = 1'b1,
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern;
    // Only the youngest PAT_W-1 bits are kept; the oldest falls out at the next shift anyway.
    logic [PAT_W-2:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        hist_nxt = {hist, data};
        fill_inc = (fill == FULL) ? fill : fill + FILL_W'(1);
        match    = (hist_nxt == pattern) && (fill_inc == FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= DEFAULT_PAT;
            hist    <= '0;
            fill    <= '0;
            flag    <= 1'b0;
        end else if (load) begin
            pattern <= pat_in;
            hist    <= '0;
            fill    <= '0;
            flag    <= 1'b0;
        end else if (valid) begin
            hist <= hist_nxt[PAT_W-2:0];
            // Non-overlapping mode demands a full fresh window after every hit.
            fill <= (match && (OVERLAP == 1'b0)) ? '0 : fill_inc;
            flag <= match;
        end else begin
            flag <= 1'b0;
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (load) begin
            match_cnt <= '0;
        end else if (valid && match && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param over three parameter sets
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data = 1'b0;
    logic       valid = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pat_in = 4'd0;

    logic       flag_a, flag_b, flag_c;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] cnt_c;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .load(load),
        .pat_in(pat_in), .flag(flag_a), .match_cnt(cnt_a));

    seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .load(load),
        .pat_in(pat_in), .flag(flag_b), .match_cnt(cnt_b));

    seq_detect_param #(.PAT_W(2), .DEFAULT_PAT(2'b10), .OVERLAP(1'b1), .CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .load(load),
        .pat_in(pat_in[1:0]), .flag(flag_c), .match_cnt(cnt_c));

    typedef struct packed {
        logic       fa;
        logic       fb;
        logic       fc;
        logic [7:0] ca;
        logic [1:0] cb;
        logic [2:0] cc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: the raw received bit stream since the last clear, pattern and count.
    bit          qa[$], qb[$], qc[$];
    logic [15:0] pa, pb, pc;
    int          na, nb, nc;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_one(input int w, input bit ov, input int cw,
                             input bit v, input bit d, input bit l, input logic [15:0] pin,
                             inout bit qq[$], inout logic [15:0] pat, inout int cnt,
                             output bit fl);
        fl = 1'b0;
        if (l) begin
            qq.delete();
            pat = pin & 16'((1 << w) - 1);
            cnt = 0;
        end else if (v) begin
            qq.push_back(d);
            if (qq.size() > 16) void'(qq.pop_front());
            if (qq.size() >= w) begin
                bit hit;
                hit = 1'b1;
                for (int i = 0; i < w; i++)
                    if (qq[qq.size() - w + i] != pat[w - 1 - i]) hit = 1'b0;
                if (hit) begin
                    fl = 1'b1;
`ifdef SEQ_DETECT_CNT_EN
                    if (cnt < (1 << cw) - 1) cnt++;
`endif
                    if (!ov) qq.delete();
                end
            end
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); qc.delete();
        pa = 16'hB; pb = 16'hB; pc = 16'h2;
        na = 0; nb = 0; nc = 0;
    endtask

    task automatic step(input bit v, input bit d, input bit l, input logic [15:0] pin);
        bit   fa, fb, fc;
        exp_t e;
        @(negedge clk);
        valid = v; data = d; load = l; pat_in = pin[3:0];
        @(posedge clk);
        model_one(4, 1'b1, 8, v, d, l, pin, qa, pa, na, fa);
        model_one(4, 1'b0, 2, v, d, l, pin, qb, pb, nb, fb);
        model_one(2, 1'b1, 3, v, d, l, pin, qc, pc, nc, fc);
        e.fa = fa; e.fb = fb; e.fc = fc;
        e.ca = 8'(na); e.cb = 2'(nb); e.cc = 3'(nc);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 16'd0);
    endtask

    // Reset is raised between edges and its effect checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        valid = 1'b0; load = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_flag_a", int'(flag_a), 0);
        chk("rst_flag_b", int'(flag_b), 0);
        chk("rst_flag_c", int'(flag_c), 0);
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_cnt_b", int'(cnt_b), 0);
        chk("rst_cnt_c", int'(cnt_c), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("flag_a", int'(flag_a), int'(e.fa));
            chk("flag_b", int'(flag_b), int'(e.fb));
            chk("flag_c", int'(flag_c), int'(e.fc));
            chk("cnt_a", int'(cnt_a), int'(e.ca));
            chk("cnt_b", int'(cnt_b), int'(e.cb));
            chk("cnt_c", int'(cnt_c), int'(e.cc));
        end
    end

    initial begin
        model_reset();
        #1;
        chk("init_flag_a", int'(flag_a), 0);
        chk("init_cnt_a", int'(cnt_a), 0);
        @(negedge clk);
        #1 reset = 1'b0;

        send(16'b1011011, 7);
        do_reset();
        send(16'b10, 2);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        send(16'b11, 2);
        do_reset();
        send(16'b101, 3);
        do_reset();
        send(16'b1, 1);
        send(16'b011, 3);
        send(16'b1011, 4);
        do_reset();
        send(16'b101, 3);
        step(1'b1, 1'b1, 1'b1, 16'b0110);
        send(16'b0110, 4);
        send(16'b1011, 4);
        do_reset();
        send(16'b1011011011011, 13);

        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) do_reset();
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 40) == 0, 16'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b0, 1'b1, 16'hF);
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, 1'b0, 16'd0);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
